// File: rtl/sequence_controller_pkg.sv
// Shared types and constants for the HALT/RUN instruction sequence controller.
package sequence_controller_pkg;

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int SC_W    = 4;
  localparam int T_COUNT = 16;
  localparam int OP_W    = 3;
  localparam int DEC_W   = 8;

  localparam int IR_I_BIT   = 15;
  localparam int IR_OP_HI   = 14;
  localparam int IR_OP_LO   = 12;
  localparam int IR_HLT_BIT = 0;

  localparam logic [SC_W-1:0] SC_ONE = SC_W'(1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(15);
  // Steps at which the IR is sampled and the HLT opcode is acted on.
  localparam logic [SC_W-1:0] T_LOAD = SC_W'(2);
  localparam logic [SC_W-1:0] T_HLT  = SC_W'(3);

  localparam logic [T_COUNT-1:0] T_ONE = T_COUNT'(1);

endpackage

// File: rtl/sequence_controller_op_decoder.sv
// 3-to-8 one-hot opcode decoder feeding the latched D0..D7 register.
module op_decoder
  import sequence_controller_pkg::*;
(
  input  logic [OP_W-1:0]  op_i,
  output logic [DEC_W-1:0] dec_o
);

  always_comb begin
    dec_o       = '0;
    dec_o[op_i] = 1'b1;
  end

endmodule

// File: rtl/sequence_controller.sv
// Sequence controller: HALT/RUN FSM, 4-bit sequence counter with one-hot T
// decode, latched opcode decode, pending-stop handling and sticky overrun flag.
module sequence_controller
  import sequence_controller_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                stall_i,
  input  logic                sc_clr_i,
  input  logic [15:0]         ir_i,
  output logic [T_COUNT-1:0]  t_o,
  output logic [DEC_W-1:0]    d_o,
  output logic                i_o,
  output logic                running_o,
  output logic                err_o
);

  state_t            state_q, state_d;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic [DEC_W-1:0]  d_q, d_d;
  logic              i_q, i_d;
  logic              err_q, err_d;
  logic              pendStop_q, pendStop_d;

  logic [DEC_W-1:0]  decOut;
  logic              isRun;
  logic              loadIr;
  logic              hltHit;

  op_decoder u_opDecoder (
    .op_i  (ir_i[IR_OP_HI:IR_OP_LO]),
    .dec_o (decOut)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HALT;
      sc_q       <= '0;
      d_q        <= '0;
      i_q        <= 1'b0;
      err_q      <= 1'b0;
      pendStop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sc_q       <= sc_d;
      d_q        <= d_d;
      i_q        <= i_d;
      err_q      <= err_d;
      pendStop_q <= pendStop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sc_d       = sc_q;
    err_d      = err_q;
    pendStop_d = pendStop_q;

    isRun  = (state_q == RUN);
    loadIr = isRun && (sc_q == T_LOAD) && !stall_i;
    hltHit = isRun && d_q[DEC_W-1] && !i_q && (sc_q == T_HLT) &&
             ir_i[IR_HLT_BIT] && !stall_i;

    d_d = loadIr ? decOut : d_q;
    i_d = loadIr ? ir_i[IR_I_BIT] : i_q;

    unique case (state_q)
      HALT: begin
        // A stop arriving with the start is remembered for the first boundary.
        if (start_i) begin
          state_d    = RUN;
          sc_d       = '0;
          err_d      = 1'b0;
          pendStop_d = stop_i;
        end
      end
      RUN: begin
        if (stop_i) begin
          pendStop_d = 1'b1;
        end
        if (sc_clr_i || hltHit) begin
          sc_d = '0;
          if (hltHit || pendStop_q) begin
            state_d    = HALT;
            pendStop_d = 1'b0;
          end
        end else if (!stall_i) begin
          sc_d = sc_q + SC_ONE;
          if (sc_q == SC_MAX) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  assign t_o       = isRun ? (T_ONE << sc_q) : '0;
  assign d_o       = d_q;
  assign i_o       = i_q;
  assign running_o = isRun;
  assign err_o     = err_q;

endmodule

// File: tb/tb_sequence_controller.sv
// Directed scoreboard bench for sequence_controller: the driver queues the
// expected outputs after each clock, the negedge monitor pops and compares.
module tb_sequence_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        stop_i;
  logic        stall_i;
  logic        sc_clr_i;
  logic [15:0] ir_i;
  logic [15:0] t_o;
  logic [7:0]  d_o;
  logic        i_o;
  logic        running_o;
  logic        err_o;

  typedef struct packed {
    logic [15:0] step;
    logic [15:0] t;
    logic [7:0]  d;
    logic        i;
    logic        run;
    logic        err;
  } expect_t;

  expect_t     expQ[$];
  int          checkCount = 0;
  int          errorCount = 0;
  logic [15:0] stepNo = 16'd0;

  sequence_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .stall_i   (stall_i),
    .sc_clr_i  (sc_clr_i),
    .ir_i      (ir_i),
    .t_o       (t_o),
    .d_o       (d_o),
    .i_o       (i_o),
    .running_o (running_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input expect_t e);
    checkCount++;
    if (t_o !== e.t) begin
      errorCount++;
      $display("[TB] FAIL step%0d t_o got %h want %h", e.step, t_o, e.t);
    end
    checkCount++;
    if (d_o !== e.d) begin
      errorCount++;
      $display("[TB] FAIL step%0d d_o got %h want %h", e.step, d_o, e.d);
    end
    checkCount++;
    if (i_o !== e.i) begin
      errorCount++;
      $display("[TB] FAIL step%0d i_o got %b want %b", e.step, i_o, e.i);
    end
    checkCount++;
    if (running_o !== e.run) begin
      errorCount++;
      $display("[TB] FAIL step%0d running_o got %b want %b", e.step, running_o, e.run);
    end
    checkCount++;
    if (err_o !== e.err) begin
      errorCount++;
      $display("[TB] FAIL step%0d err_o got %b want %b", e.step, err_o, e.err);
    end
  endtask

  task automatic pushExpect(input logic [15:0] eT, input logic [7:0] eD,
                            input logic eI, input logic eRun, input logic eErr);
    expect_t e;
    stepNo++;
    e.step = stepNo;
    e.t    = eT;
    e.d    = eD;
    e.i    = eI;
    e.run  = eRun;
    e.err  = eErr;
    expQ.push_back(e);
  endtask

  // Inputs are held for exactly one rising edge; the expectation describes the
  // outputs after that edge.
  task automatic applyStimulus(input logic st, input logic sp, input logic stl,
                               input logic clr, input logic [15:0] ir,
                               input logic [15:0] eT, input logic [7:0] eD,
                               input logic eI, input logic eRun, input logic eErr);
    start_i  = st;
    stop_i   = sp;
    stall_i  = stl;
    sc_clr_i = clr;
    ir_i     = ir;
    @(posedge clk);
    #1;
    start_i  = 1'b0;
    stop_i   = 1'b0;
    stall_i  = 1'b0;
    sc_clr_i = 1'b0;
    pushExpect(eT, eD, eI, eRun, eErr);
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  initial begin
    expect_t zeroExp;
    rst_n    = 1'b1;
    start_i  = 1'b0;
    stop_i   = 1'b0;
    stall_i  = 1'b0;
    sc_clr_i = 1'b0;
    ir_i     = 16'h0000;
    #1 rst_n = 1'b0;
    #1 pushExpect(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic sequence with IR latch at T2 and clear at T4.
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'h0000, 16'h0001, 8'h00, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0002, 8'h00, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 16'hB123, 16'h0004, 8'h00, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 16'hB123, 16'h0008, 8'h08, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 16'hB123, 16'h0010, 8'h08, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 16'h0000, 16'h0001, 8'h08, 1, 1, 0);

    // Stall at T1 for three cycles, then HLT opcode.
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0002, 8'h08, 1, 1, 0);
    applyStimulus(0, 0, 1, 0, 16'h0000, 16'h0002, 8'h08, 1, 1, 0);
    applyStimulus(0, 0, 1, 0, 16'h0000, 16'h0002, 8'h08, 1, 1, 0);
    applyStimulus(0, 0, 1, 0, 16'h0000, 16'h0002, 8'h08, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 16'h7001, 16'h0004, 8'h08, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 16'h7001, 16'h0008, 8'h80, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 16'h7001, 16'h0000, 8'h80, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000, 8'h80, 0, 0, 0);

    // Stop in HALT is ignored; then sixteen steps without clear wrap SC.
    applyStimulus(0, 1, 0, 0, 16'h0000, 16'h0000, 8'h80, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'h0000, 16'h0001, 8'h80, 0, 1, 0);
    for (int k = 1; k < 16; k++) begin
      logic [15:0] tExp;
      logic [7:0]  dExp;
      tExp = 16'h0001 << k;
      dExp = (k >= 3) ? 8'h01 : 8'h80;
      applyStimulus(0, 0, 0, 0, 16'h0000, tExp, dExp, 0, 1, 0);
    end
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0001, 8'h01, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0002, 8'h01, 0, 1, 1);
    applyStimulus(1, 0, 0, 0, 16'h0000, 16'h0004, 8'h01, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 16'h0000, 16'h0001, 8'h01, 0, 1, 1);
    applyStimulus(0, 1, 0, 0, 16'h0000, 16'h0002, 8'h01, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 16'h0000, 16'h0000, 8'h01, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 16'h0000, 16'h0001, 8'h01, 0, 1, 0);

    // Stop at T1 takes effect on the clear at T5.
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0002, 8'h01, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 16'h0000, 16'h0004, 8'h01, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0008, 8'h01, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0010, 8'h01, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0020, 8'h01, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 16'h0000, 16'h0000, 8'h01, 0, 0, 0);

    // Start and stop together: run one instruction, halt on its clear.
    applyStimulus(1, 1, 0, 0, 16'h0000, 16'h0001, 8'h01, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0002, 8'h01, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 16'h0000, 16'h0000, 8'h01, 0, 0, 0);

    // Asynchronous reset pulse at T2, released before the next rising edge.
    applyStimulus(1, 0, 0, 0, 16'h0000, 16'h0001, 8'h01, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0002, 8'h01, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 16'hB123, 16'h0004, 8'h01, 0, 1, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    zeroExp = '0;
    zeroExp.step = 16'hFFFF;
    checkOutput(zeroExp);
    #1 rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 16'hB123, 16'h0000, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'h0000, 16'h0001, 8'h00, 0, 1, 0);

    // Clear wins over a coincident stall.
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0002, 8'h00, 0, 1, 0);
    applyStimulus(0, 0, 1, 1, 16'h0000, 16'h0001, 8'h00, 0, 1, 0);

    for (int w = 0; w < 20 && expQ.size() != 0; w++) begin
      @(negedge clk);
      #1;
    end
    checkCount++;
    if (expQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL drain queue left %0d want 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/sequence_controller.md
SEQUENCE_CONTROLLER -- requirements
Module: sequence_controller

Interface
REQ-001 The block SHALL use these ports; clock and reset first; one clock; reset is asynchronous and active-low:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  single-cycle pulse; leaves HALT
- stop_i  in  1  single-cycle pulse; halt request at the next instruction boundary
- stall_i  in  1  datapath/memory busy; freezes the sequence counter (SC)
- sc_clr_i  in  1  execute step finished; SC returns to 0
- ir_i  in  16  current IR contents (I bit = ir_i[15], opcode = ir_i[14:12])
- t_o  out  16  one-hot timing signals T0..T15
- d_o  out  8  one-hot latched opcode decode D0..D7
- i_o  out  1  latched indirect bit
- running_o  out  1  1 in RUN
- err_o  out  1  sticky SC-overrun flag

Function
REQ-002 The state machine SHALL have exactly two states, HALT and RUN, held in one register.
REQ-003 SC SHALL be a 4-bit register; in RUN, t_o[k] = 1 iff SC == k; in HALT, t_o SHALL be 16'h0000.
REQ-004 HALT -> RUN on a start_i pulse; SC = 0 on entry, so T0 is asserted in the first RUN cycle.
REQ-005 In RUN, SC priority per clock edge SHALL be: sc_clr_i -> 0; else stall_i -> hold; else SC + 1.
REQ-006 When SC == 15, no clear and no stall, SC SHALL wrap to 0 and err_o SHALL set, staying 1 until the next start_i.
REQ-007 While T2 is asserted and stall_i = 0, d_o and i_o SHALL load from ir_i on that clock edge:
- d_o = one-hot(ir_i[14:12])
- i_o = ir_i[15]
REQ-008 Outside REQ-007, d_o and i_o SHALL hold their values.
REQ-009 HLT decode: if D7 = 1, i_o = 0, T3 is active, ir_i[0] = 1 and stall_i = 0, the block SHALL enter HALT at the next edge with SC = 0.
REQ-010 A stop_i pulse in RUN SHALL set a pending-stop flag; the next edge that clears SC (sc_clr_i or HLT) SHALL enter HALT and clear the flag.
REQ-011 start_i while in RUN SHALL be ignored; stop_i while in HALT SHALL be ignored.
REQ-012 If start_i and stop_i coincide in HALT, the block SHALL enter RUN with the pending-stop flag set.
REQ-013 If sc_clr_i and stall_i coincide, clear SHALL win.
REQ-014 All outputs SHALL be registered or decoded only from registers, with no combinational path from inputs.
REQ-015 Timing signal latency SHALL be one clock per step when not stalled.

Reset
REQ-016 When rst_n = 0, asynchronously, the block SHALL set:
- state = HALT, SC = 0
- t_o = 0, d_o = 0, i_o = 0
- running_o = 0, err_o = 0
- pending-stop flag = 0
REQ-017 Reset asserted mid-instruction SHALL abort the instruction with no further T outputs until start_i follows reset release.

Structure
REQ-018 A shared package SHALL hold:
- the HALT/RUN state typedef
- the SC width (4) and T-count (16)
- IR field positions: I = 15, opcode = 14:12, HLT bit = 0
- SC_MAX = 15
REQ-019 The 3-to-8 opcode decoder SHALL be a separate sub-module, op_decoder; the 4-to-16 timing decode SHALL stay inline.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then start_i; no stall, sc_clr_i at T4 -> t_o sequence 0001, 0002, 0004, 0008, 0010, 0001; running_o = 1.
- ir_i = 16'hB123 at T2 -> d_o = 8'h08, i_o = 1 after that edge; values held through T3..T4.
- stall_i high for 3 cycles at T1 -> t_o = 16'h0002 for 4 cycles total, then 16'h0004.
- ir_i = 16'h7001 (D7, I = 0, bit0 = 1) -> HALT after T3; t_o = 0; running_o = 0.
- No sc_clr_i for 16 steps -> SC wraps to T0 and err_o = 1; err_o clears on the next start_i.
- stop_i at T1, sc_clr_i at T5 -> HALT after the T5 edge; rst_n pulled low at T2 -> all outputs 0 immediately.
